// File: rtl/se_pkg.sv
// Shared types and IR field positions for the field sequencer.
package se_pkg;
   localparam int IR_W  = 32;
   localparam int REG_W = 4;
   localparam int OPC_W = 5;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;
   localparam int C_MSB   = 18;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SRC_B = 3'd1,
      S_SRC_C = 3'd2,
      S_DST_A = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_RA   = 2'd1,
      SEL_RB   = 2'd2,
      SEL_RC   = 2'd3
   } field_sel_t;
endpackage

// File: rtl/se_field_mux.sv
// Combinational selection of one of the Ra/Rb/Rc register fields; SEL_NONE yields 0.
module se_field_mux
   import se_pkg::*;
(
   input  field_sel_t       sel,
   input  logic [REG_W-1:0] ra,
   input  logic [REG_W-1:0] rb,
   input  logic [REG_W-1:0] rc,
   output logic [REG_W-1:0] code
);
   always_comb begin
      code = '0;
      case (sel)
         SEL_RA:  code = ra;
         SEL_RB:  code = rb;
         SEL_RC:  code = rc;
         default: code = '0;
      endcase
   end
endmodule

// File: rtl/se_field_sequencer.sv
// Rb-out / Rc-out / Ra-in register-transfer sequencer with manual field select in IDLE.
// Optional macro SE_SIGN_EXT_EN adds the registered sign-extended C-field output.
module se_field_sequencer
   import se_pkg::*;
(
   input  logic             clk,
   input  logic             clear,
   input  logic [IR_W-1:0]  ir_in,
   input  logic             ir_ld,
   input  logic             start,
   input  logic             step,
   input  logic             gra,
   input  logic             grb,
   input  logic             grc,
   input  logic             rin,
   input  logic             rout,
   input  logic             baout,
   output logic [REG_W-1:0] decoder_in,
   output logic             r_in_en,
   output logic             r_out_en,
   output logic             ba_out,
   output logic             busy,
   output logic             done,
   output logic [OPC_W-1:0] opcode,
   output logic [IR_W-1:0]  c_sign_ext
);
   state_t           state, state_n;
   logic [IR_W-1:0]  ir_q, ir_next;
   field_sel_t       sel;
   logic [REG_W-1:0] dec_n;
   logic             rin_n, rout_n, ba_n;
   logic             manual;

   // Outputs are registered from the next state, so the sequence fields come
   // from ir_next: a load accepted together with start is already visible.
   assign ir_next = (ir_ld && (state == S_IDLE || state == S_DONE)) ? ir_in : ir_q;
   assign opcode  = ir_q[OPC_MSB:OPC_LSB];

   se_field_mux u_field_mux (
      .sel  (sel),
      .ra   (ir_next[RA_MSB:RA_LSB]),
      .rb   (ir_next[RB_MSB:RB_LSB]),
      .rc   (ir_next[RC_MSB:RC_LSB]),
      .code (dec_n)
   );

   always_comb begin
      state_n = state;
      sel     = SEL_NONE;
      rin_n   = 1'b0;
      rout_n  = 1'b0;
      ba_n    = 1'b0;
      case (state)
         S_IDLE:  if (start) state_n = S_SRC_B;
         S_SRC_B: if (step)  state_n = S_SRC_C;
         S_SRC_C: if (step)  state_n = S_DST_A;
         S_DST_A: if (step)  state_n = S_DONE;
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      manual = (state == S_IDLE) && (state_n == S_IDLE);
      case (state_n)
         S_SRC_B: begin sel = SEL_RB; rout_n = 1'b1; end
         S_SRC_C: begin sel = SEL_RC; rout_n = 1'b1; end
         S_DST_A: begin sel = SEL_RA; rin_n  = 1'b1; end
         S_IDLE: begin
            if (manual) begin
               sel    = gra ? SEL_RA : grb ? SEL_RB : grc ? SEL_RC : SEL_NONE;
               rin_n  = rin;
               // rin wins a simultaneous manual in/out request so the bus never sees both
               rout_n = rout & ~rin;
               ba_n   = baout;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!clear) begin
         state      <= S_IDLE;
         ir_q       <= '0;
         decoder_in <= '0;
         r_in_en    <= 1'b0;
         r_out_en   <= 1'b0;
         ba_out     <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         ir_q       <= ir_next;
         decoder_in <= dec_n;
         r_in_en    <= rin_n;
         r_out_en   <= rout_n;
         ba_out     <= ba_n;
         busy       <= (state_n != S_IDLE);
         done       <= (state_n == S_DONE);
      end
   end

`ifdef SE_SIGN_EXT_EN
   function automatic logic [IR_W-1:0] sign_ext_c(input logic [IR_W-1:0] ir);
      logic signed [C_MSB:0] c_field;
      c_field = ir[C_MSB:0];
      return IR_W'(c_field);
   endfunction

   logic [IR_W-1:0] c_q;

   always_ff @(posedge clk) begin
      if (!clear) c_q <= '0;
      else        c_q <= sign_ext_c(ir_next);
   end

   assign c_sign_ext = c_q;
`else
   assign c_sign_ext = '0;
`endif
endmodule

// File: doc/se_field_sequencer.md
SE_FIELD_SEQUENCER -- requirements
Module: se_field_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 clear  input  1  synchronous, active-low reset.
REQ-004 ir_in  input  32  instruction word from the IR.
REQ-005 ir_ld  input  1  capture ir_in into the internal IR copy.
REQ-006 start  input  1  one-cycle pulse that begins the Rb-out, Rc-out, Ra-in sequence.
REQ-007 step  input  1  control-unit advance strobe while a sequence is running.
REQ-008 gra / grb / grc  input  1 each  manual field select, used only in IDLE.
REQ-009 rin / rout / baout  input  1 each  manual register-strobe requests, used only in IDLE.
REQ-010 decoder_in  output  4  register code to the 4-to-16 select decoder.
REQ-011 r_in_en / r_out_en / ba_out  output  1 each  gated register strobes.
REQ-012 busy  output  1  high while the FSM is not in IDLE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 opcode  output  5  IR[31:27].
REQ-015 c_sign_ext  output  32  sign-extended C field.

Function
REQ-016 IR fields SHALL be: opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15], C [18:0].
REQ-017 ir_ld SHALL load the IR copy only in IDLE or DONE; ir_ld is ignored in SRC_B, SRC_C and DST_A.
REQ-018 FSM states SHALL be IDLE, SRC_B, SRC_C, DST_A and DONE.
REQ-019 Transitions SHALL be: IDLE + start -> SRC_B; SRC_B + step -> SRC_C; SRC_C + step -> DST_A; DST_A + step -> DONE; DONE -> IDLE unconditionally; with no step the FSM holds its state.
REQ-020 In SRC_B, decoder_in SHALL be Rb and r_out_en SHALL be 1.
REQ-021 In SRC_C, decoder_in SHALL be Rc and r_out_en SHALL be 1.
REQ-022 In DST_A, decoder_in SHALL be Ra and r_in_en SHALL be 1.
REQ-023 In DONE, done SHALL be 1 and all strobes SHALL be 0.
REQ-024 All outputs SHALL be registered: state-driven outputs appear in the cycle the state is entered.
REQ-025 Manual mode (IDLE, no start) SHALL drive decoder_in from the selected field one cycle after the request, with priority gra > grb > grc; with no select, decoder_in SHALL be 0.
REQ-026 In manual mode, r_in_en, r_out_en and ba_out SHALL copy rin, rout and baout with one cycle of latency.
REQ-027 When start and manual inputs are both asserted, start SHALL win and the manual inputs SHALL be ignored.
REQ-028 start SHALL be ignored while busy.
REQ-029 When ir_ld and start are asserted together in IDLE, the sequence SHALL use the newly loaded IR.
REQ-030 r_in_en and r_out_en SHALL never be 1 in the same cycle.
REQ-031 opcode SHALL be a combinational view of the IR copy.

Reset
REQ-032 When clear = 0 at a clock edge, the block SHALL set state = IDLE, IR copy = 0, decoder_in = 0, all strobes = 0, busy = 0, done = 0 and c_sign_ext = 0.
REQ-033 A reset during a running sequence SHALL abort it with no done pulse.

Configuration
REQ-034 With SE_SIGN_EXT_EN defined, c_sign_ext SHALL be registered as {13 copies of IR[18], IR[18:0]} and SHALL update the cycle after ir_ld.
REQ-035 Without SE_SIGN_EXT_EN, c_sign_ext SHALL be tied to 0 and no extension register SHALL exist.

Structure
REQ-036 Package se_pkg SHALL hold the FSM state enum and the field bit-position constants.
REQ-037 One sub-module, se_field_mux, SHALL perform the combinational Ra/Rb/Rc field selection.

Verification
REQ-038 Reset with clear = 0 mid-sequence at SRC_C -> next cycle busy = 0, decoder_in = 0, all strobes = 0, no done pulse.
REQ-039 Load IR 0x1A9B8000 (Ra = 5, Rb = 3, Rc = 7); pulse start, then step three times -> decoder_in goes 3 (r_out_en), 7 (r_out_en), 5 (r_in_en), then done = 1 for one cycle.
REQ-040 In IDLE, assert gra and grc together with IR Ra = 5, Rc = 7 -> decoder_in = 5 one cycle later.
REQ-041 Pulse start while in SRC_B, plus ir_ld with a new word -> no restart, IR unchanged, sequence completes with the old fields.
REQ-042 With SE_SIGN_EXT_EN, load C = 0x40000 -> c_sign_ext = 0xFFFC0000; load C = 0x3FFFF -> c_sign_ext = 0x0003FFFF.
REQ-043 Assert start and rout in the same IDLE cycle -> FSM enters SRC_B and the rout request has no effect.
